// File: rtl/alu_disp_pkg.sv
// Shared constants and types for the ALU result display: segment patterns,
// the hex glyph table and the digit-scan index encoding.
package alu_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so HEX_SEG[n] is glyph n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_e;

  function automatic logic [3:0] an_select(input dig_e d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decoder
  import alu_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/alu_result_display.sv
// Latches ALU answer/opcode and scans them onto a 4-digit common-anode
// display as "op - hi lo", with a blanking window at the start of each slot.
module alu_result_display
  import alu_disp_pkg::*;
#(
  parameter int unsigned NUM_WIDTH    = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WIDTH-1:0] answer,
  input  logic [3:0]           opcode,
  input  logic                 valid,
  input  logic                 hold,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [3:0]           an,
  output logic                 updated
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [NUM_WIDTH-1:0] ans_q, ans_d;
  logic [3:0]           op_q, op_d;
  logic                 upd_q, upd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  dig_e                 state_q, state_d;
  logic [6:0]           seg_q, seg_d;
  logic [3:0]           an_q, an_d;
  logic                 dp_q, dp_d;
  logic [3:0]           nib;
  logic [6:0]           dec_seg;

  always_comb begin
    ans_d = ans_q;
    op_d  = op_q;
    upd_d = 1'b0;
    if (valid && !hold) begin
      ans_d = answer;
      op_d  = opcode;
      upd_d = ({answer, opcode} != {ans_q, op_q});
    end
  end

  always_comb begin
    cnt_d   = cnt_q + CNT_ONE;
    state_d = state_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      unique case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        DIG2:    state_d = DIG3;
        default: state_d = DIG0;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      DIG0:    nib = ans_q[3:0];
      DIG1:    nib = ans_q[7:4];
      DIG2:    nib = '0;
      default: nib = op_q;
    endcase
  end

  seg7_hex_decoder u_dec (
    .nibble_i (nib),
    .seg_o    (dec_seg)
  );

  // Outputs reflect the current count/index/latched values one cycle later.
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (cnt_q >= CNT_BLANK) begin
      an_d  = an_select(state_q);
      seg_d = (state_q == DIG2) ? SEG_DASH : dec_seg;
      dp_d  = !((state_q == DIG3) && op_q[3]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q   <= '0;
      op_q    <= '0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= DIG0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
    end else begin
      ans_q   <= ans_d;
      op_q    <= op_d;
      upd_q   <= upd_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign updated = upd_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display: behavioural display model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_display;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLANK = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] answer = '0;
  logic [3:0] opcode = '0;
  logic       valid = 1'b0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       updated;

  int errors = 0;
  int checks = 0;

  alu_result_display #(
    .NUM_WIDTH    (8),
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .answer  (answer),
    .opcode  (opcode),
    .valid   (valid),
    .hold    (hold),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .updated (updated)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Model: elapsed cycles since reset determine slot and blanking directly.
  int unsigned t;
  int unsigned m_pos, m_slot;
  logic [7:0]  m_ans;
  logic [3:0]  m_op;
  logic [6:0]  e_seg = 7'h7F;
  logic [3:0]  e_an = 4'hF;
  logic        e_dp = 1'b1;
  logic        e_upd = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      t = 0; m_ans = '0; m_op = '0;
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_upd = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_pos  = t % DIV;
      m_slot = (t / DIV) % 4;
      if (m_pos < BLANK) begin
        e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
      end else begin
        e_an = 4'hF;
        e_an[m_slot] = 1'b0;
        case (m_slot)
          0: e_seg = glyph(m_ans[3:0]);
          1: e_seg = glyph(m_ans[7:4]);
          2: e_seg = 7'h3F;
          default: e_seg = glyph(m_op);
        endcase
        e_dp = !(m_slot == 3 && m_op >= 4'h8);
      end
      e_upd = valid && !hold && ({answer, opcode} != {m_ans, m_op});
      if (valid && !hold) begin
        m_ans = answer;
        m_op  = opcode;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({seg, dp, an, updated} !== {e_seg, e_dp, e_an, e_upd}) begin
        errors++;
        $display("FAIL model @%0t: got seg=%h dp=%b an=%h upd=%b, expected seg=%h dp=%b an=%h upd=%b",
                 $time, seg, dp, an, updated, e_seg, e_dp, e_an, e_upd);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot @%0t: an=%h has more than one digit enabled", $time, an);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== target && n < 40);
    if (an !== target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, an=%h expected %h", name, an, target);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_lit("reset_seg", {1'b0, seg}, 8'h7F);
    check_lit("reset_an", {4'h0, an}, 8'h0F);
    check_lit("reset_upd", {7'h0, updated}, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check_lit("first_blank_an", {4'h0, an}, 8'h0F);
    check_lit("first_blank_seg", {1'b0, seg}, 8'h7F);
    @(negedge clk);
    check_lit("dig0_an", {4'h0, an}, 8'h0E);
    check_lit("dig0_zero", {1'b0, seg}, 8'h40);
    wait_an(4'hB, "wait_dig2");
    check_lit("dig2_dash", {1'b0, seg}, 8'h3F);

    // capture A5 / op 3
    valid = 1'b1; answer = 8'hA5; opcode = 4'h3;
    @(negedge clk);
    valid = 1'b0;
    check_lit("upd_A5", {7'h0, updated}, 8'h01);
    wait_an(4'hE, "wait_A5_d0");
    check_lit("A5_d0", {1'b0, seg}, 8'h12);
    wait_an(4'hD, "wait_A5_d1");
    check_lit("A5_d1", {1'b0, seg}, 8'h08);
    wait_an(4'h7, "wait_A5_d3");
    check_lit("A5_d3", {1'b0, seg}, 8'h30);
    check_lit("A5_dp", {7'h0, dp}, 8'h01);

    // upper-bank opcode lights dp on digit 3
    valid = 1'b1; answer = 8'h00; opcode = 4'h9;
    @(negedge clk);
    valid = 1'b0;
    wait_an(4'h7, "wait_op9");
    check_lit("op9_seg", {1'b0, seg}, 8'h10);
    check_lit("op9_dp", {7'h0, dp}, 8'h00);
    wait_an(4'hE, "wait_op9_d0");
    check_lit("op9_d0_dp", {7'h0, dp}, 8'h01);

    // hold blocks capture
    valid = 1'b1; hold = 1'b1; answer = 8'hFF;
    @(negedge clk);
    valid = 1'b0; hold = 1'b0;
    check_lit("hold_upd", {7'h0, updated}, 8'h00);
    wait_an(4'hE, "wait_hold_d0");
    check_lit("hold_keeps", {1'b0, seg}, 8'h40);
    valid = 1'b1; answer = 8'hFF; opcode = 4'h9;
    @(negedge clk);
    valid = 1'b0;
    check_lit("FF_upd", {7'h0, updated}, 8'h01);
    wait_an(4'hE, "wait_FF_d0");
    check_lit("FF_d0", {1'b0, seg}, 8'h0E);

    // identical back-to-back captures
    valid = 1'b1; answer = 8'h3C; opcode = 4'h2;
    @(negedge clk);
    check_lit("same_first", {7'h0, updated}, 8'h01);
    @(negedge clk);
    valid = 1'b0;
    check_lit("same_second", {7'h0, updated}, 8'h00);

    // reset during DIG2 visible window
    wait_an(4'hB, "wait_rst_dig2");
    reset = 1'b1;
    @(negedge clk);
    check_lit("midrst_an", {4'h0, an}, 8'h0F);
    check_lit("midrst_seg", {1'b0, seg}, 8'h7F);
    reset = 1'b0;
    @(negedge clk);
    check_lit("midrst_blank", {4'h0, an}, 8'h0F);
    @(negedge clk);
    check_lit("midrst_an_dig0", {4'h0, an}, 8'h0E);
    check_lit("midrst_zero", {1'b0, seg}, 8'h40);

    // randomized traffic; the model comparator checks every cycle
    for (int i = 0; i < 2000; i++) begin
      reset  = ($urandom_range(0, 249) == 0);
      valid  = $urandom_range(0, 1);
      hold   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        answer = 8'($urandom);
        opcode = 4'($urandom);
      end
      @(negedge clk);
    end
    reset = 1'b0; valid = 1'b0; hold = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
Output-side consumer of the ALU datapath. It latches the 8-bit `answer` and the 4-bit `opcode` produced by the controller/ALU pair. It drives a 4-digit, time-multiplexed, common-anode 7-segment display.
Digit layout:
- digit3 = opcode (hex)
- digit2 = dash
- digit1 = answer[7:4] (hex)
- digit0 = answer[3:0] (hex)

It sits beside ALU_Top at board top level, between `answer`/`opcode` and the board display pins.

Parameters:
- NUM_WIDTH, 8, width of the answer input; fixed at 8 for the 2-digit hex field.
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range 2 and up.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); must be less than REFRESH_DIV.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- answer, input, NUM_WIDTH, ALU result.
- opcode, input, 4, current ALU opcode from the controller.
- valid, input, 1, capture strobe; answer and opcode are sampled on a rising clk edge while valid=1.
- hold, input, 1, freeze; while 1, valid is ignored and the latched values are kept.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1, decimal point, active-low.
- an, output, 4, digit anodes, active-low, an[0]=digit0.
- updated, output, 1, one-cycle pulse on the cycle after a capture whose value differs from the previous latched value.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state is updated only on rising clk.
- Reset values:
  - ans_q=0, op_q=0, refresh count=0, digit index=0.
  - seg=7'h7F, dp=1, an=4'hF, updated=0.
- Capture:
  - If valid=1 and hold=0: ans_q<=answer and op_q<=opcode at that edge.
  - updated=1 on the next cycle iff {answer,opcode} differs from the prior {ans_q,op_q}.
  - Captures are back-to-back capable, one per cycle.
  - hold=1 with valid=1 produces no capture and updated=0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit index advances 0→1→2→3→0.
  - The counter is free-running and unaffected by valid/hold.
- Scan FSM has four states, DIG0..DIG3, one per digit index.
  - Within a slot, when count < BLANK_CYCLES: an=4'hF and seg=7'h7F.
  - Otherwise: an = one-hot-low for the index, and seg = decode of the selected nibble.
- Nibble select:
  - DIG0 = ans_q[3:0]
  - DIG1 = ans_q[7:4]
  - DIG2 = dash (only segment g lit, seg=7'h3F)
  - DIG3 = op_q
- Hex encoding is standard 0-F (lower-case b and d).
- dp is lit (0) only on DIG3 when op_q is greater than or equal to 4'h8; it marks the upper opcode bank.
- Latency: seg/an/dp are registered, one cycle after the count/index/latched values they reflect.
- A capture landing mid-slot takes effect on the displayed digit one cycle later. There is no slot restart.
- Reset mid-scan: outputs go to their reset values at the next edge. Scanning resumes at DIG0 with count=0.
- Exactly one an bit is low outside blanking; never more than one at any time.

Decomposition:
- Shared package `alu_disp_pkg`:
  - seg7 constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - The 16-entry hex-to-segment constant table.
  - Digit-index encoding DIG0..DIG3 (2-bit).
- One natural combinational sub-module, `seg7_hex_decoder`: 4-bit nibble in, 7-bit active-low segments out.
- The top block holds the capture registers, refresh counter, scan FSM and output registers.

Test Plan:
All scenarios use REFRESH_DIV=4 and BLANK_CYCLES=1.
- Reset hold then release, no valid → first cycle an=F, seg=7F; after blank, DIG0 shows "0" (seg=7'h40); scan order an=E,D,B,7 repeating every 16 cycles; DIG2 always seg=3F.
- valid=1 for one cycle with answer=8'hA5, opcode=4'h3 → updated=1 next cycle; DIG0 seg=7'h12 ("5"); DIG1 seg=7'h08 ("A"); DIG3 seg=7'h30 ("3"); dp=1 throughout.
- Capture opcode=4'h9, answer=8'h00 → DIG3 "9" (seg=7'h10) with dp=0; dp=1 on all other digits.
- hold=1 while valid=1 with answer=8'hFF → display keeps the prior value and updated stays 0. Release hold and pulse valid → FF is shown and updated=1.
- Capture the same {answer,opcode} twice consecutively → updated=1 only after the first capture.
- Assert reset during DIG2 non-blank → next cycle an=F and seg=7F; after release, scanning restarts at DIG0 and latched values read 0.
